// File: rtl/memboard_pkg.sv
// memboard_pkg: shared ADC sequencer state encoding and default converter constants
`timescale 1ns/1ps
package memboard_pkg;
    localparam int ADC_DATA_W   = 16;
    localparam int ADC_SCLK_DIV = 3;
    localparam int ADC_TIMEOUT  = 255;
    typedef enum logic [2:0] {IDLE, CNV, WAIT_HI, WAIT_LO, READ, STROBE, ERR} state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level, resets to 0
`timescale 1ns/1ps
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk)
        if (rst) {q, m} <= '0;
        else {q, m} <= {m, d};
endmodule

// File: rtl/adc_conv_seq.sv
// adc_conv_seq: drives CNVST/CS/SCLK of the dual-lane serial ADC and delivers sample pairs
`timescale 1ns/1ps
module adc_conv_seq
    import memboard_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int SCLK_DIV = ADC_SCLK_DIV,
    parameter int CNV_LOW  = 4,
    parameter int TIMEOUT  = ADC_TIMEOUT,
    parameter int CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CNT_W-1:0]  nsamp,
    input  logic              abort,
    output logic              ready,
    output logic [DATA_W-1:0] sample_a,
    output logic [DATA_W-1:0] sample_b,
    output logic              sample_valid,
    output logic              done,
    output logic              timeout_err,
    output logic              CNVST_ADC,
    output logic              CS_ADC,
    output logic              SCLK_ADC,
    input  logic              BUSY_ADC,
    input  logic              DOUTA_ADC,
    input  logic              DOUTB_ADC
);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int LOW_W = $clog2(CNV_LOW + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [LOW_W-1:0] LOW_END  = LOW_W'(CNV_LOW);
    localparam logic [TO_W-1:0]  TO_END   = TO_W'(TIMEOUT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t state, state_n;
    logic busy_s, accept, tick, rise, last, fin;
    logic cnvst_n, cs_n, sclk_n, abort_l;
    logic [LOW_W-1:0] cnt;
    logic [TO_W-1:0] tcnt;
    logic [DIV_W-1:0] div;
    logic [BIT_W-1:0] bcnt;
    logic [DATA_W-1:0] sh_a, sh_b;
    logic [CNT_W-1:0] rem;

    sync2 u_busy (.clk(CLK), .rst(RST), .d(BUSY_ADC), .q(busy_s));

    assign ready  = state == IDLE && !done;
    assign accept = start && ready;

    always_comb begin
        tick    = div == DIV_LAST;
        rise    = state == READ && tick && !SCLK_ADC;
        last    = rise && bcnt == BIT_LAST;
        fin     = rem == CNT_W'(1) || abort_l || abort;
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? CNV : IDLE;
            CNV:     state_n = cnt == LOW_END ? WAIT_HI : CNV;
            WAIT_HI: state_n = busy_s ? WAIT_LO : tcnt == TO_END ? ERR : WAIT_HI;
            WAIT_LO: state_n = !busy_s ? READ : tcnt == TO_END ? ERR : WAIT_LO;
            READ:    state_n = last ? STROBE : READ;
            STROBE:  state_n = fin ? IDLE : CNV;
            default: state_n = IDLE;
        endcase
        // pin next-values: CNVST low one edge after entering CNV, SCLK parks high outside READ
        cnvst_n = !(state == CNV && cnt != LOW_END);
        cs_n    = state_n != READ;
        sclk_n  = state != READ || (tick ? !SCLK_ADC : SCLK_ADC);
    end

    always_ff @(posedge CLK)
        if (RST) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            {CNVST_ADC, CS_ADC, SCLK_ADC} <= '1;
            {sample_valid, done, timeout_err, abort_l} <= '0;
            sample_a <= '0;
            sample_b <= '0;
            sh_a <= '0;
            sh_b <= '0;
            cnt <= '0;
            tcnt <= '0;
            div <= '0;
            bcnt <= '0;
            rem <= '0;
        end else begin
            CNVST_ADC <= cnvst_n;
            CS_ADC <= cs_n;
            SCLK_ADC <= sclk_n;
            cnt <= state == CNV ? cnt + 1'b1 : '0;
            tcnt <= (state == WAIT_HI || state == WAIT_LO) ? tcnt + 1'b1 : '0;
            div <= (state == READ && !tick) ? div + 1'b1 : '0;
            if (rise) begin
                bcnt <= bcnt + 1'b1;
                sh_a <= {sh_a[DATA_W-2:0], DOUTA_ADC};
                sh_b <= {sh_b[DATA_W-2:0], DOUTB_ADC};
            end else if (state != READ) bcnt <= '0;
            sample_valid <= state == STROBE;
            done <= (state == STROBE && fin) || state == ERR;
            abort_l <= state != IDLE && (abort_l || abort);
            if (state == STROBE) begin
                sample_a <= sh_a;
                sample_b <= sh_b;
            end
            if (accept) rem <= nsamp == '0 ? CNT_W'(1) : nsamp;
            else if (state == STROBE) rem <= rem - 1'b1;
            if (accept) timeout_err <= 1'b0;
            else if (state == ERR) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_conv_seq.sv
// tb_adc_conv_seq: behavioural ADC model plus event-timestamp scoreboard for adc_conv_seq
`timescale 1ns/1ps
module tb_adc_conv_seq;
    import memboard_pkg::*;
    localparam int DW = ADC_DATA_W;
    localparam int DIV = ADC_SCLK_DIV;
    localparam int CL = 4;
    localparam int TO = ADC_TIMEOUT;

    logic CLK = 0, RST = 1, start = 0, abort = 0;
    logic [7:0] nsamp = 0;
    logic ready, sample_valid, done, timeout_err, CNVST_ADC, CS_ADC, SCLK_ADC;
    logic [DW-1:0] sample_a, sample_b;
    logic BUSY_ADC = 0, DOUTA_ADC = 0, DOUTB_ADC = 0;

    int tests = 0, fails = 0, cyc = 0;
    int fall_q[$], rise_q[$], valid_q[$], done_q[$];
    int n_rise = 0, cs_fall = 0, last_rise = 0, k = 0, acc = 0;
    logic [DW-1:0] exp_a[$], exp_b[$], pat_a[$], pat_b[$];
    logic [DW-1:0] cur_a = 0, cur_b = 0;
    bit busy_en = 1;
    logic p_cnv = 1, p_sclk = 1, p_cs = 1;

    adc_conv_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .nsamp(nsamp), .abort(abort),
        .ready(ready), .sample_a(sample_a), .sample_b(sample_b),
        .sample_valid(sample_valid), .done(done), .timeout_err(timeout_err),
        .CNVST_ADC(CNVST_ADC), .CS_ADC(CS_ADC), .SCLK_ADC(SCLK_ADC),
        .BUSY_ADC(BUSY_ADC), .DOUTA_ADC(DOUTA_ADC), .DOUTB_ADC(DOUTB_ADC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC: BUSY 40 ns after CNVST falls for 720 ns; a new word per CS frame, next bit 20 ns after each SCLK fall
    always @(negedge CNVST_ADC)
        if (busy_en) begin
            #40 BUSY_ADC = 1;
            #720 BUSY_ADC = 0;
        end

    always @(negedge CS_ADC) begin
        if (pat_a.size() > 0) begin
            cur_a = pat_a.pop_front();
            cur_b = pat_b.pop_front();
        end else begin
            cur_a = DW'($urandom);
            cur_b = DW'($urandom);
        end
        exp_a.push_back(cur_a);
        exp_b.push_back(cur_b);
        k = DW;
    end

    always @(negedge SCLK_ADC)
        if (!CS_ADC && k > 0) begin
            #20;
            k--;
            DOUTA_ADC = cur_a[k];
            DOUTB_ADC = cur_b[k];
        end

    always @(posedge CLK) begin
        cyc++;
        #1;
        if (p_cnv && !CNVST_ADC) fall_q.push_back(cyc);
        if (!p_cnv && CNVST_ADC) rise_q.push_back(cyc);
        if (p_cs && !CS_ADC) cs_fall = cyc;
        if (!p_sclk && SCLK_ADC) begin
            n_rise++;
            last_rise = cyc;
        end
        if (sample_valid) begin
            valid_q.push_back(cyc);
            if (exp_a.size() > 0) begin
                chk("sample_a", sample_a, exp_a.pop_front());
                chk("sample_b", sample_b, exp_b.pop_front());
            end else chk("valid_unexpected", sample_valid, 0);
        end
        if (done) done_q.push_back(cyc);
        p_cnv = CNVST_ADC;
        p_sclk = SCLK_ADC;
        p_cs = CS_ADC;
    end

    task automatic clr();
        fall_q.delete();
        rise_q.delete();
        valid_q.delete();
        done_q.delete();
        n_rise = 0;
    endtask

    task automatic go(input int n);
        @(negedge CLK);
        start = 1;
        nsamp = 8'(n);
        @(negedge CLK);
        start = 0;
        acc = cyc;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (done_q.size() > 0) return;
        end
        chk("done_wait_expired", done_q.size(), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("reset_pins", {CNVST_ADC, CS_ADC, SCLK_ADC}, 3'b111);
        chk("reset_ready", ready, 1);
        chk("reset_strobes", {sample_valid, done, timeout_err}, 0);
        chk("reset_samples", {sample_a, sample_b}, 0);
        RST = 0;
        idle(2);

        // single conversion with fixed patterns
        clr();
        pat_a.push_back(16'hA5C3);
        pat_b.push_back(16'h5A3C);
        go(1);
        wait_done(400);
        chk("t1_ready_in_done", ready, 0);
        idle(1);
        chk("t1_ready_after", ready, 1);
        chk("t1_sclk_rises", n_rise, DW);
        chk("t1_cnv_fall", fall_q[0], acc + 1);
        chk("t1_cnv_rise", rise_q[0], acc + 1 + CL);
        chk("t1_read_len", last_rise - cs_fall, 2 * DIV * DW);
        chk("t1_valid_lat", valid_q[0], last_rise + 1);
        chk("t1_valid_count", valid_q.size(), 1);
        chk("t1_done_with_valid", done_q[0], valid_q[0]);
        chk("t1_data", {sample_a, sample_b}, 32'hA5C3_5A3C);

        // burst of three
        clr();
        go(3);
        wait_done(1200);
        idle(5);
        chk("t2_valid_count", valid_q.size(), 3);
        chk("t2_done_count", done_q.size(), 1);
        chk("t2_done_last", done_q[0], valid_q[2]);
        chk("t2_cnv_after_v1", fall_q[1], valid_q[0] + 1);
        chk("t2_cnv_after_v2", fall_q[2], valid_q[1] + 1);
        chk("t2_cnv_count", fall_q.size(), 3);
        chk("t2_exp_drained", exp_a.size(), 0);

        // BUSY never rises: ERR entered TIMEOUT+1 cycles after CNVST rise, done one cycle later
        clr();
        busy_en = 0;
        go(2);
        wait_done(600);
        idle(3);
        chk("t3_err_time", done_q[0] - rise_q[0], TO + 2);
        chk("t3_timeout_err", timeout_err, 1);
        chk("t3_no_valid", valid_q.size(), 0);
        chk("t3_cnv_count", fall_q.size(), 1);
        busy_en = 1;
        clr();
        go(1);
        chk("t3_err_cleared", timeout_err, 0);
        wait_done(400);
        chk("t3_recover_valid", valid_q.size(), 1);

        // abort during READ of conversion 2
        clr();
        go(5);
        for (int i = 0; i < 2000 && !(fall_q.size() == 2 && !CS_ADC && n_rise >= DW + 4); i++)
            @(negedge CLK);
        abort = 1;
        @(negedge CLK);
        abort = 0;
        wait_done(800);
        idle(300);
        chk("t4_valid_count", valid_q.size(), 2);
        chk("t4_done_with_v2", done_q[0], valid_q[1]);
        chk("t4_cnv_count", fall_q.size(), 2);
        chk("t4_done_count", done_q.size(), 1);
        abort = 1;
        @(negedge CLK);
        abort = 0;
        clr();
        go(2);
        wait_done(800);
        idle(5);
        chk("t4_idle_abort_ignored", valid_q.size(), 2);

        // reset in the middle of READ
        clr();
        go(1);
        for (int i = 0; i < 1000 && n_rise < 3; i++) @(negedge CLK);
        RST = 1;
        @(posedge CLK);
        #1;
        chk("t5_pins_high", {CNVST_ADC, CS_ADC, SCLK_ADC}, 3'b111);
        chk("t5_ready", ready, 1);
        @(negedge CLK);
        RST = 0;
        clr();
        idle(300);
        chk("t5_no_valid", valid_q.size(), 0);
        chk("t5_no_done", done_q.size(), 0);
        exp_a.delete();
        exp_b.delete();
        clr();
        go(1);
        wait_done(400);
        chk("t5_fresh_valid", valid_q.size(), 1);

        // start while busy is ignored; nsamp=0 runs once
        clr();
        go(1);
        idle(20);
        go(1);
        wait_done(400);
        idle(300);
        chk("t6_busy_start_cnv", fall_q.size(), 1);
        chk("t6_busy_start_valid", valid_q.size(), 1);
        clr();
        go(0);
        wait_done(400);
        idle(300);
        chk("t6_n0_cnv", fall_q.size(), 1);
        chk("t6_n0_valid", valid_q.size(), 1);

        // random burst lengths
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(0, 3));
            clr();
            go(n);
            wait_done(1200);
            idle(5);
            chk("rnd_valid_count", valid_q.size(), n == 0 ? 1 : n);
            chk("rnd_done_count", done_q.size(), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
